// File: rtl/accel_spi_responder.sv
// accel_spi_responder
//   SPI (mode 3) register-slave for a 3-axis accelerometer front end.
//   Frames are 16 bits: R/W, MB, 6-bit address, 8-bit data, MSB first.
//   New axis samples land in the X/Y/Z data registers and raise DATA_READY.
//   Samples that arrive while CSN is low wait in a one-deep shadow until CSN
//   rises, so a transaction never sees a half-updated sample.
//
// Optional feature: define ACCEL_SPI_RESPONDER_MULTIBYTE_EN to honour the MB
//   bit (burst access with auto-incrementing address). Without it, every frame
//   carries one data byte.
//
// Ports
//   clk           system clock, >= 8x SPI_CLK
//   reset         synchronous, active-low
//   SPI_CLK/CSN/SDI  asynchronous SPI inputs from the initiator
//   SPI_SDO       serial read data (1 while deselected)
//   sample_x/y/z  16-bit two's-complement axis measurements
//   sample_valid  one-clk qualifier for sample_*
//   interrupt     [0]=INT1, [1]=INT2, level, registered
//   measure       POWER_CTL (0x2D) bit 3
module accel_spi_responder #(
    parameter logic [7:0] DEVICE_ID   = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SPI_CLK,
    input  logic        SPI_CSN,
    input  logic        SPI_SDI,
    output logic        SPI_SDO,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic [1:0]  interrupt,
    output logic        measure
);

    typedef enum logic [1:0] {IDLE, COMMAND, DATA, HOLD} state_t;

    localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, sdi_sync;
    logic       sclk_s, csn_s, sdi_s, sclk_d, csn_d;
    logic       sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic [2:0] settle;
    logic       armed;

    state_t     state, state_next;
    logic [2:0] bit_cnt;
    logic       byte_done, burst;
    logic       cmd_rw;
    logic [5:0] addr, wr_addr;
    logic [7:0] wr_data;
    logic       load_pend, wr_pend, rd_int_done;
    logic [6:0] shift_in;
    logic [7:0] tx_shift, rd_byte;
    logic       sdo_bit;
`ifdef ACCEL_SPI_RESPONDER_MULTIBYTE_EN
    logic       cmd_mb;
`endif

    logic [7:0]  regs [64];
    logic [15:0] data_x, data_y, data_z;
    logic [15:0] shadow_x, shadow_y, shadow_z;
    logic [15:0] commit_x, commit_y, commit_z;
    logic        shadow_valid, data_ready, take, commit;
    logic [7:0]  int_src;

    function automatic logic is_writable(input logic [5:0] a);
        return (a >= 6'h1D && a <= 6'h2F) || a == 6'h31 || a == 6'h38 || a == 6'h39;
    endfunction

    // Synchronizers and edge detectors; idle level is 1 for all three lines.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync <= '1;
            csn_sync  <= '1;
            sdi_sync  <= '1;
            sclk_d    <= 1'b1;
            csn_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], SPI_CSN};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SPI_SDI};
            sclk_d    <= sclk_s;
            csn_d     <= csn_s;
        end
    end

    // The synchronizer resets to "CSN high", so right after reset a CSN that
    // is still low would look like a falling edge. Only arm frame detection
    // once the chain has flushed and CSN has been seen high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            settle <= 3'd0;
            armed  <= 1'b0;
        end else if (settle != SETTLE) begin
            settle <= settle + 3'd1;
        end else if (csn_s) begin
            armed <= 1'b1;
        end
    end

    always_comb begin
        sclk_s    = sclk_sync[SYNC_STAGES-1];
        csn_s     = csn_sync[SYNC_STAGES-1];
        sdi_s     = sdi_sync[SYNC_STAGES-1];
        sclk_rise = sclk_s & ~sclk_d;
        sclk_fall = ~sclk_s & sclk_d;
        csn_rise  = csn_s & ~csn_d;
        csn_fall  = armed & ~csn_s & csn_d;
        byte_done = sclk_rise && (bit_cnt == 3'd7);
    end

`ifdef ACCEL_SPI_RESPONDER_MULTIBYTE_EN
    assign burst = cmd_mb;
`else
    assign burst = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (csn_fall)  state_next = COMMAND;
            COMMAND: if (byte_done) state_next = DATA;
            DATA:    if (byte_done) state_next = burst ? DATA : HOLD;
            HOLD:    state_next = HOLD;
        endcase
        if (csn_rise) state_next = IDLE;
    end

    // Frame control: bit counting, command decode, write/read-load requests.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt     <= 3'd0;
            cmd_rw      <= 1'b0;
            addr        <= 6'd0;
            wr_addr     <= 6'd0;
            wr_data     <= 8'd0;
            load_pend   <= 1'b0;
            wr_pend     <= 1'b0;
            rd_int_done <= 1'b0;
`ifdef ACCEL_SPI_RESPONDER_MULTIBYTE_EN
            cmd_mb      <= 1'b0;
`endif
        end else begin
            load_pend <= 1'b0;
            wr_pend   <= 1'b0;
            if (csn_fall) begin
                bit_cnt     <= 3'd0;
                rd_int_done <= 1'b0;
            end else if (sclk_rise && (state == COMMAND || state == DATA)) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (state == COMMAND) begin
                        cmd_rw    <= shift_in[6];
`ifdef ACCEL_SPI_RESPONDER_MULTIBYTE_EN
                        cmd_mb    <= shift_in[5];
`endif
                        addr      <= {shift_in[4:0], sdi_s};
                        load_pend <= shift_in[6];
                    end else begin
                        if (!cmd_rw) begin
                            wr_pend <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= {shift_in, sdi_s};
                        end else if (addr == 6'h30) begin
                            rd_int_done <= 1'b1;
                        end
                        if (burst) begin
                            addr      <= addr + 6'd1;
                            load_pend <= cmd_rw;
                        end
                    end
                end
            end
        end
    end

    // Serial shifters carry only data; their contents are qualified by state.
    always_ff @(posedge clk) begin
        if (sclk_rise) shift_in <= {shift_in[5:0], sdi_s};
        if (load_pend) begin
            tx_shift <= rd_byte;
        end else if (sclk_fall && state == DATA && cmd_rw) begin
            sdo_bit  <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (addr)
            6'h00:   rd_byte = DEVICE_ID;
            6'h30:   rd_byte = int_src;
            6'h32:   rd_byte = data_x[7:0];
            6'h33:   rd_byte = data_x[15:8];
            6'h34:   rd_byte = data_y[7:0];
            6'h35:   rd_byte = data_y[15:8];
            6'h36:   rd_byte = data_z[7:0];
            6'h37:   rd_byte = data_z[15:8];
            default: if (is_writable(addr)) rd_byte = regs[addr];
        endcase
    end

    always_comb begin
        SPI_SDO = 1'b0;
        if (state == IDLE)                  SPI_SDO = 1'b1;
        else if (state == DATA && cmd_rw)   SPI_SDO = sdo_bit;
    end

    // A fresh sample beats the shadow when both are ready in the same clk.
    always_comb begin
        take     = sample_valid && measure;
        commit   = csn_s && (take || shadow_valid);
        commit_x = take ? sample_x : shadow_x;
        commit_y = take ? sample_y : shadow_y;
        commit_z = take ? sample_z : shadow_z;
        int_src  = {data_ready, 7'b0};
        measure  = regs[6'h2D][3];
    end

    // Register file, sample capture, DATA_READY and interrupt outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
            regs[6'h2C]  <= 8'h0A;
            data_x       <= 16'd0;
            data_y       <= 16'd0;
            data_z       <= 16'd0;
            shadow_x     <= 16'd0;
            shadow_y     <= 16'd0;
            shadow_z     <= 16'd0;
            shadow_valid <= 1'b0;
            data_ready   <= 1'b0;
            interrupt    <= 2'b00;
        end else begin
            if (wr_pend && !csn_s && is_writable(wr_addr)) regs[wr_addr] <= wr_data;

            if (csn_s) begin
                shadow_valid <= 1'b0;
            end else if (take) begin
                shadow_valid <= 1'b1;
                shadow_x     <= sample_x;
                shadow_y     <= sample_y;
                shadow_z     <= sample_z;
            end

            if (commit) begin
                data_x     <= commit_x;
                data_y     <= commit_y;
                data_z     <= commit_z;
                data_ready <= 1'b1;
            end else if (csn_rise && rd_int_done) begin
                data_ready <= 1'b0;
            end

            interrupt <= {|(int_src & regs[6'h2E] & regs[6'h2F]),
                          |(int_src & regs[6'h2E] & ~regs[6'h2F])};
        end
    end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Testbench for accel_spi_responder: directed SPI frames; expected read bytes
// go into a queue and a passive SPI monitor pops and compares each completed
// read byte.
module tb_accel_spi_responder;

    localparam int HALF = 8;   // clk cycles per SPI half period

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        SPI_CLK = 1'b1;
    logic        SPI_CSN = 1'b1;
    logic        SPI_SDI = 1'b1;
    logic        SPI_SDO;
    logic [15:0] sample_x = 16'd0, sample_y = 16'd0, sample_z = 16'd0;
    logic        sample_valid = 1'b0;
    logic [1:0]  interrupt;
    logic        measure;

    accel_spi_responder dut (
        .clk(clk), .reset(reset),
        .SPI_CLK(SPI_CLK), .SPI_CSN(SPI_CSN), .SPI_SDI(SPI_SDI), .SPI_SDO(SPI_SDO),
        .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
        .sample_valid(sample_valid), .interrupt(interrupt), .measure(measure)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic expect_byte(input string name, input logic [7:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Monitor: decodes the command byte from SDI, then collects SDO per byte.
    int         mon_bits = 0;
    logic [7:0] mon_cmd = 8'd0;
    logic [7:0] mon_rx = 8'd0;

    always @(negedge SPI_CSN) mon_bits = 0;

    always @(posedge SPI_CLK) begin
        if (!SPI_CSN) begin
            if (mon_bits < 8) mon_cmd = {mon_cmd[6:0], SPI_SDI};
            else              mon_rx  = {mon_rx[6:0], SPI_SDO};
            mon_bits++;
            if (mon_bits >= 16 && mon_bits % 8 == 0 && mon_cmd[7]) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL unexpected_read: got %02h, expected nothing", mon_rx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(e.name, mon_rx, e.val);
                end
            end
        end
    end

    task automatic spi_start();
        @(negedge clk);
        SPI_CSN = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_shift(input logic [55:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            SPI_CLK = 1'b0;
            SPI_SDI = v[i];
            repeat (HALF) @(negedge clk);
            SPI_CLK = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic spi_stop();
        SPI_CSN = 1'b1;
        SPI_SDI = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        spi_start();
        spi_shift({40'd0, 2'b00, a, d}, 16);
        spi_stop();
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string name);
        expect_byte(name, exp);
        spi_start();
        spi_shift({40'd0, 2'b10, a, 8'h00}, 16);
        spi_stop();
    endtask

    // Six-byte MB read starting at 0x32; without burst support only the
    // first byte carries data and the rest read as 0.
    task automatic burst_xyz(input logic [47:0] b, input string name);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] v;
            v = b[47 - 8*i -: 8];
`ifdef ACCEL_SPI_RESPONDER_MULTIBYTE_EN
            expect_byte($sformatf("%s_b%0d", name, i), v);
`else
            expect_byte($sformatf("%s_b%0d", name, i), (i == 0) ? v : 8'h00);
`endif
        end
        spi_start();
        spi_shift({8'hF2, 48'd0}, 56);
        spi_stop();
    endtask

    task automatic pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        sample_x = x;
        sample_y = y;
        sample_z = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_sdo", {7'd0, SPI_SDO}, 8'h01);
        check("rst_interrupt", {6'd0, interrupt}, 8'h00);
        check("rst_measure", {7'd0, measure}, 8'h00);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        rd(6'h00, 8'hE5, "devid");
        rd(6'h2C, 8'h0A, "bw_rate_rst");
        rd(6'h2D, 8'h00, "power_ctl_rst");
        wr(6'h2D, 8'h08);
        rd(6'h2D, 8'h08, "power_ctl_rb");
        check("measure_on", {7'd0, measure}, 8'h01);
        wr(6'h32, 8'hFF);
        rd(6'h32, 8'h00, "datax0_readonly");
        wr(6'h00, 8'h12);
        rd(6'h00, 8'hE5, "devid_readonly");
        wr(6'h3A, 8'h55);
        rd(6'h3A, 8'h00, "unmapped");

        pulse(16'h1234, 16'hABCD, 16'h8001);
        rd(6'h32, 8'h34, "x_lo");
        rd(6'h33, 8'h12, "x_hi");
        rd(6'h37, 8'h80, "z_hi");

        fork
            burst_xyz(48'h3412_CDAB_0180, "burst_old");
            begin
                repeat (100) @(negedge clk);
                pulse(16'h5678, 16'h9ABC, 16'hDEF0);
            end
        join
        burst_xyz(48'h7856_BC9A_F0DE, "burst_new");
        rd(6'h34, 8'hBC, "y_lo_new");

        wr(6'h2E, 8'h80);
        wr(6'h2F, 8'h80);
        check("int2_set", {6'd0, interrupt}, 8'h02);
        rd(6'h30, 8'h80, "int_source");
        check("int_cleared", {6'd0, interrupt}, 8'h00);
        rd(6'h30, 8'h00, "int_source_clr");

        wr(6'h2F, 8'h00);
        pulse(16'h0102, 16'h0304, 16'h0506);
        check("int1_set", {6'd0, interrupt}, 8'h01);
        fork
            rd(6'h30, 8'h80, "int_source_race");
            begin
                repeat (100) @(negedge clk);
                pulse(16'h1111, 16'h2222, 16'h3333);
            end
        join
        check("int_kept_by_sample", {6'd0, interrupt}, 8'h01);
        rd(6'h30, 8'h80, "int_source_kept");
        check("int_cleared2", {6'd0, interrupt}, 8'h00);
        rd(6'h32, 8'h11, "x_lo_shadow");

        spi_start();
        spi_shift(56'h2C0, 12);
        spi_stop();
        rd(6'h2C, 8'h0A, "bw_rate_abort");

        spi_start();
        spi_shift(56'h7, 5);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_measure", {7'd0, measure}, 8'h00);
        check("rst_mid_sdo", {7'd0, SPI_SDO}, 8'h01);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        spi_shift(56'h05A, 11);
        spi_stop();
        rd(6'h38, 8'h00, "no_stray_write");
        wr(6'h31, 8'h0B);
        rd(6'h31, 8'h0B, "data_format");
        rd(6'h2D, 8'h00, "power_ctl_after_reset");

        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_mis++;
            $display("FAIL %s: got no read byte, expected %02h", e.name, e.val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "timeout");
    end

endmodule
